// File: rtl/bsg_arb_bypass_hold_if.sv
// Handshake bundle between the requesters/consumer and the bypass-hold arbiter.
// The arbiter connects to the slave modport; the driving side connects to the master modport.
interface bsg_arb_bypass_hold_if #(
    parameter int els_p   = 4,
    parameter int width_p = 32
);
    localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1;

    logic [els_p-1:0]         v_i;
    logic [els_p*width_p-1:0] data_i;
    logic [els_p-1:0]         yumi_o;
    logic                     v_o;
    logic [width_p-1:0]       data_o;
    logic [lg_els_lp-1:0]     grant_id_o;
    logic                     ready_i;

    modport master (
        output v_i, data_i, ready_i,
        input  yumi_o, v_o, data_o, grant_id_o
    );

    modport slave (
        input  v_i, data_i, ready_i,
        output yumi_o, v_o, data_o, grant_id_o
    );
endinterface

// File: rtl/bsg_arb_bypass_hold.sv
// Round-robin arbiter that bypasses the granted word straight to the consumer and
// parks it in a single holding register when the consumer stalls.
module bsg_arb_bypass_hold #(
    parameter  int els_p     = 4,
    parameter  int width_p   = 32,
    localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    bsg_arb_bypass_hold_if.slave    bus
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e               r_state;
    logic [lg_els_lp-1:0] r_ptr;
    logic [width_p-1:0]   r_data;
    logic [lg_els_lp-1:0] r_id;

    state_e               w_stateNext;
    logic [lg_els_lp-1:0] w_ptrNext;
    logic [width_p-1:0]   w_dataNext;
    logic [lg_els_lp-1:0] w_idNext;

    logic                 w_found;
    logic [lg_els_lp-1:0] w_grant;
    logic [width_p-1:0]   w_grantData;

    logic                 w_vOut;
    logic [els_p-1:0]     w_yumi;
    logic [width_p-1:0]   w_dataOut;
    logic [lg_els_lp-1:0] w_idOut;

    function automatic logic [lg_els_lp-1:0] wrapIdx(input logic [lg_els_lp-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= els_p) sum = sum - els_p;
        return lg_els_lp'(sum);
    endfunction

    // Scan from the farthest offset back toward ptr so the nearest valid requester wins.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int i = els_p - 1; i >= 0; i--) begin
            if (bus.v_i[wrapIdx(r_ptr, i)]) begin
                w_found = 1'b1;
                w_grant = wrapIdx(r_ptr, i);
            end
        end
        w_grantData = bus.data_i[int'(w_grant)*width_p +: width_p];
    end

    always_comb begin
        w_stateNext = r_state;
        w_ptrNext   = r_ptr;
        w_dataNext  = r_data;
        w_idNext    = r_id;
        w_vOut      = 1'b0;
        w_yumi      = '0;
        w_dataOut   = '0;
        w_idOut     = '0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_vOut          = 1'b1;
                    w_yumi[w_grant] = 1'b1;
                    w_dataOut       = w_grantData;
                    w_idOut         = w_grant;
                    w_ptrNext       = (w_grant == lg_els_lp'(els_p - 1)) ? '0 : w_grant + lg_els_lp'(1);
                    if (!bus.ready_i) begin
                        w_stateNext = HOLD;
                        w_dataNext  = w_grantData;
                        w_idNext    = w_grant;
                    end
                end
            end
            HOLD: begin
                w_vOut    = 1'b1;
                w_dataOut = r_data;
                w_idOut   = r_id;
                if (bus.ready_i) w_stateNext = IDLE;
            end
        endcase
        // Outputs are forced quiet for the whole time reset is held, not just after the edge.
        if (!reset_n_i) begin
            w_vOut    = 1'b0;
            w_yumi    = '0;
            w_dataOut = '0;
            w_idOut   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_data  <= '0;
            r_id    <= '0;
        end else begin
            r_state <= w_stateNext;
            r_ptr   <= w_ptrNext;
            r_data  <= w_dataNext;
            r_id    <= w_idNext;
        end
    end

    assign bus.v_o        = w_vOut;
    assign bus.yumi_o     = w_yumi;
    assign bus.data_o     = w_dataOut;
    assign bus.grant_id_o = w_idOut;

endmodule

// File: tb/tb_bsg_arb_bypass_hold.sv
// Directed bench for bsg_arb_bypass_hold with els_p=4, width_p=32.
module tb_bsg_arb_bypass_hold;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;

    bsg_arb_bypass_hold_if #(.els_p(4), .width_p(32)) bus ();

    bsg_arb_bypass_hold #(.els_p(4), .width_p(32)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
    task automatic sampleOutputs();
        @(negedge clk);
    endtask

    task automatic endCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        bus.v_i     = 4'b1111;
        bus.ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sampleOutputs();
            vectors++;
            if (bus.v_o !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_v_o cycle %0d: got %b expected 0", c, bus.v_o);
            end
            vectors++;
            if (bus.yumi_o !== 4'b0000) begin
                miscompares++;
                $display("[TB] FAIL reset_yumi cycle %0d: got %b expected 0000", c, bus.yumi_o);
            end
            endCycle();
        end
        reset_n = 1'b1;
        sampleOutputs();
        vectors++;
        if (bus.v_o !== 1'b1 || bus.grant_id_o !== 2'd0 || bus.yumi_o !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL first_grant: got v=%b id=%0d yumi=%b expected v=1 id=0 yumi=0001",
                     bus.v_o, bus.grant_id_o, bus.yumi_o);
        end
        endCycle();
    endtask

    // Enters with ptr=1; leaves with ptr=0.
    task automatic test_bypass();
        bus.v_i           = 4'b0100;
        bus.data_i[64+:32] = 32'hDEADBEEF;
        bus.ready_i       = 1'b1;
        sampleOutputs();
        vectors++;
        if (bus.v_o !== 1'b1 || bus.data_o !== 32'hDEADBEEF || bus.grant_id_o !== 2'd2 || bus.yumi_o !== 4'b0100) begin
            miscompares++;
            $display("[TB] FAIL bypass: got v=%b data=%h id=%0d yumi=%b expected v=1 data=deadbeef id=2 yumi=0100",
                     bus.v_o, bus.data_o, bus.grant_id_o, bus.yumi_o);
        end
        endCycle();
        bus.v_i = 4'b1011;
        sampleOutputs();
        vectors++;
        if (bus.grant_id_o !== 2'd3 || bus.yumi_o !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL bypass_ptr: got id=%0d yumi=%b expected id=3 yumi=1000", bus.grant_id_o, bus.yumi_o);
        end
        endCycle();
    endtask

    // Enters with ptr=0; leaves with ptr=2.
    task automatic test_stall_hold();
        bus.v_i            = 4'b0010;
        bus.data_i[32+:32] = 32'h12345678;
        bus.ready_i        = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus.ready_i = (c == 3);
            sampleOutputs();
            vectors++;
            if (bus.v_o !== 1'b1 || bus.data_o !== 32'h12345678 || bus.grant_id_o !== 2'd1) begin
                miscompares++;
                $display("[TB] FAIL hold_data cycle %0d: got v=%b data=%h id=%0d expected v=1 data=12345678 id=1",
                         c, bus.v_o, bus.data_o, bus.grant_id_o);
            end
            vectors++;
            if (bus.yumi_o !== ((c == 0) ? 4'b0010 : 4'b0000)) begin
                miscompares++;
                $display("[TB] FAIL hold_yumi cycle %0d: got %b expected %b",
                         c, bus.yumi_o, (c == 0) ? 4'b0010 : 4'b0000);
            end
            endCycle();
            bus.data_i[32+:32] = 32'hFFFF0000;
        end
        sampleOutputs();
        vectors++;
        if (bus.v_o !== 1'b1 || bus.data_o !== 32'hFFFF0000 || bus.grant_id_o !== 2'd1 || bus.yumi_o !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL after_hold: got v=%b data=%h id=%0d yumi=%b expected v=1 data=ffff0000 id=1 yumi=0010",
                     bus.v_o, bus.data_o, bus.grant_id_o, bus.yumi_o);
        end
        endCycle();
    endtask

    // Resets first so the sequence starts at 0; leaves with ptr=2.
    task automatic test_round_robin();
        logic [1:0] expId;
        bus.v_i = 4'b0000;
        reset_n = 1'b0;
        endCycle();
        reset_n     = 1'b1;
        bus.v_i     = 4'b1111;
        bus.ready_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            expId = 2'(c % 4);
            sampleOutputs();
            vectors++;
            if (bus.grant_id_o !== expId || bus.yumi_o !== (4'b0001 << expId) || bus.v_o !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL round_robin cycle %0d: got id=%0d yumi=%b v=%b expected id=%0d yumi=%b v=1",
                         c, bus.grant_id_o, bus.yumi_o, bus.v_o, expId, 4'b0001 << expId);
            end
            endCycle();
        end
    endtask

    // Enters with ptr=2; uses one grant of requester 0 to bring ptr to 1.
    task automatic test_sparse_skip();
        logic [1:0] expIds [3];
        logic [3:0] vecs [3];
        expIds = '{2'd0, 2'd3, 2'd0};
        vecs   = '{4'b0001, 4'b1001, 4'b1001};
        bus.ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.v_i = vecs[c];
            sampleOutputs();
            vectors++;
            if (bus.grant_id_o !== expIds[c] || bus.yumi_o !== (4'b0001 << expIds[c])) begin
                miscompares++;
                $display("[TB] FAIL sparse step %0d: got id=%0d yumi=%b expected id=%0d yumi=%b",
                         c, bus.grant_id_o, bus.yumi_o, expIds[c], 4'b0001 << expIds[c]);
            end
            endCycle();
        end
    endtask

    // Enters with ptr=1.
    task automatic test_reset_mid_hold();
        bus.v_i            = 4'b0100;
        bus.data_i[64+:32] = 32'hA5A5A5A5;
        bus.ready_i        = 1'b0;
        sampleOutputs();
        vectors++;
        if (bus.grant_id_o !== 2'd2 || bus.data_o !== 32'hA5A5A5A5) begin
            miscompares++;
            $display("[TB] FAIL mid_hold_grant: got id=%0d data=%h expected id=2 data=a5a5a5a5", bus.grant_id_o, bus.data_o);
        end
        endCycle();
        bus.v_i = 4'b0000;
        sampleOutputs();
        vectors++;
        if (bus.v_o !== 1'b1 || bus.data_o !== 32'hA5A5A5A5) begin
            miscompares++;
            $display("[TB] FAIL mid_hold_held: got v=%b data=%h expected v=1 data=a5a5a5a5", bus.v_o, bus.data_o);
        end
        endCycle();
        reset_n     = 1'b0;
        bus.ready_i = 1'b1;
        sampleOutputs();
        vectors++;
        if (bus.v_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_hold_during_reset: got v=%b expected 0", bus.v_o);
        end
        endCycle();
        reset_n = 1'b1;
        sampleOutputs();
        vectors++;
        if (bus.v_o !== 1'b0 || bus.data_o !== 32'h0 || bus.grant_id_o !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL mid_hold_after_reset: got v=%b data=%h id=%0d expected v=0 data=0 id=0",
                     bus.v_o, bus.data_o, bus.grant_id_o);
        end
        endCycle();
        bus.v_i = 4'b1111;
        sampleOutputs();
        vectors++;
        if (bus.grant_id_o !== 2'd0 || bus.data_o === 32'hA5A5A5A5) begin
            miscompares++;
            $display("[TB] FAIL mid_hold_ptr: got id=%0d data=%h expected id=0 and no held word", bus.grant_id_o, bus.data_o);
        end
        endCycle();
    endtask

    initial begin
        clk         = 1'b0;
        reset_n     = 1'b0;
        vectors     = 0;
        miscompares = 0;
        bus.v_i     = '0;
        bus.data_i  = '0;
        bus.ready_i = 1'b0;
        #1;
        test_reset();
        test_bypass();
        test_stall_hold();
        test_round_robin();
        test_sparse_skip();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
